// File: rtl/sound_pkg.sv
// Shared definitions for the sound path: sound codes (also used by the animation)
// and the tone FSM state encoding.
package sound_pkg;

  localparam logic [1:0] STOP = 2'b00;
  localparam logic [1:0] PONG = 2'b01;
  localparam logic [1:0] PING = 2'b10;
  localparam logic [1:0] GO   = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    TONE_A = 2'b01,
    TONE_B = 2'b10
  } state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period counter producing a square-wave tone bit; reloaded with the
// selected half-period minus one on load or on every wrap.
module tone_divider #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         load,
  input  logic         clear,
  input  logic         en,
  input  logic [W-1:0] reload,
  output logic         tone
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         tone_q, tone_d;

  always_comb begin
    cnt_d  = cnt_q;
    tone_d = tone_q;
    if (load) begin
      cnt_d  = reload;
      tone_d = 1'b0;
    end else if (clear) begin
      cnt_d  = '0;
      tone_d = 1'b0;
    end else if (en) begin
      if (cnt_q == '0) begin
        cnt_d  = reload;
        tone_d = ~tone_q;
      end else begin
        cnt_d = cnt_q - W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      cnt_q  <= '0;
      tone_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tone_q <= tone_d;
    end
  end

  assign tone = tone_q;

endmodule

// File: rtl/sound_player.sv
// Tone generator: plays ping, pong or go (ping then pong) for a fixed duration
// on a trigger; owns all audio timing so the animation stays clock-rate independent.
module sound_player
  import sound_pkg::*;
#(
  parameter int PING_HALF = 28409,
  parameter int PONG_HALF = 56818,
  parameter int DUR       = 2500000
) (
  input  logic       clk,
  input  logic       clr,
  input  logic [1:0] code_sound,
  input  logic       trigger,
  input  logic       mute,
  output logic       speaker,
  output logic       busy,
  output logic [1:0] active_code
);

  localparam int CW = $clog2(max3(PING_HALF, PONG_HALF, DUR));
  localparam logic [CW-1:0] PING_RELOAD = CW'(PING_HALF - 1);
  localparam logic [CW-1:0] PONG_RELOAD = CW'(PONG_HALF - 1);
  localparam logic [CW-1:0] DUR_RELOAD  = CW'(DUR - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] dur_q, dur_d;
  logic [1:0]    code_q, code_d;
  logic          busy_q, busy_d;
  logic          div_load, div_clear, div_en;
  logic [CW-1:0] half_sel;
  logic          tone;

  always_comb begin
    state_d   = state_q;
    dur_d     = dur_q;
    code_d    = code_q;
    busy_d    = busy_q;
    div_load  = 1'b0;
    div_clear = 1'b0;
    div_en    = 1'b0;
    half_sel  = PING_RELOAD;
    if (trigger) begin
      if (code_sound == STOP) begin
        state_d   = IDLE;
        dur_d     = '0;
        code_d    = STOP;
        busy_d    = 1'b0;
        div_clear = 1'b1;
      end else begin
        state_d  = TONE_A;
        dur_d    = DUR_RELOAD;
        code_d   = code_sound;
        busy_d   = 1'b1;
        div_load = 1'b1;
        half_sel = (code_sound == PONG) ? PONG_RELOAD : PING_RELOAD;
      end
    end else if (state_q != IDLE) begin
      if (dur_q == '0) begin
        // Go chains into a pong segment; everything else ends here.
        if (state_q == TONE_A && code_q == GO) begin
          state_d  = TONE_B;
          dur_d    = DUR_RELOAD;
          div_load = 1'b1;
          half_sel = PONG_RELOAD;
        end else begin
          state_d   = IDLE;
          code_d    = STOP;
          busy_d    = 1'b0;
          div_clear = 1'b1;
        end
      end else begin
        dur_d    = dur_q - CW'(1);
        div_en   = 1'b1;
        half_sel = (state_q == TONE_B || code_q == PONG) ? PONG_RELOAD : PING_RELOAD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      dur_q   <= '0;
      code_q  <= STOP;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dur_q   <= dur_d;
      code_q  <= code_d;
      busy_q  <= busy_d;
    end
  end

  tone_divider #(.W(CW)) u_div (
    .clk    (clk),
    .clr    (clr),
    .load   (div_load),
    .clear  (div_clear),
    .en     (div_en),
    .reload (half_sel),
    .tone   (tone)
  );

  // Mute gates the pin only, so the tone phase keeps running underneath.
  assign speaker     = tone & ~mute;
  assign busy        = busy_q;
  assign active_code = code_q;

endmodule

// File: doc/sound_player.md
# sound_player

Tone generator sitting directly downstream of the bouncing-numbers animation. It accepts a sound code (stop, ping, pong, go) together with a one-cycle trigger. It drives a square wave on the board speaker pin for a fixed duration, with pitch chosen by the code. The animation raises the trigger on every border hit; this block owns all audio timing so the animation logic stays clock-rate independent.

## Interface
- `PING_HALF`, default 28409: half-period of the ping tone in clk cycles (≈440 Hz at 25 MHz); must be ≥ 2.
- `PONG_HALF`, default 56818: half-period of the pong tone (≈220 Hz); must be ≥ 2.
- `DUR`, default 2500000: length of one tone segment in clk cycles (100 ms); must be ≥ 2.

- `clk`: input, 1 bit. System clock; the only clock.
- `clr`: input, 1 bit. Reset, synchronous, active-high.
- `code_sound`: input, 2 bits. Sound code, sampled only when `trigger`=1.
- `trigger`: input, 1 bit. Single-cycle request to start the sound given by `code_sound`.
- `mute`: input, 1 bit. Level input; forces the speaker low without affecting timing.
- `speaker`: output, 1 bit. Square-wave output.
- `busy`: output, 1 bit. High while a tone segment is playing.
- `active_code`: output, 2 bits. Code currently playing; stop (00) when idle.

## Operation
- Codes: stop=00, pong=01, ping=10, go=11.
- FSM states are IDLE, TONE_A and TONE_B.
  - IDLE: `busy`=0, internal tone bit 0, `active_code`=00.
  - TONE_A: plays the ping pitch for ping and go, and the pong pitch for pong.
  - TONE_B: used only by go; plays the pong pitch. Go is therefore ping followed by pong, total 2·DUR cycles.
- Trigger acceptance, in any state:
  - With code stop: go to IDLE immediately (abort).
  - With any other code: go to TONE_A. Load `half_cnt`=HALF−1 and `dur_cnt`=DUR−1, set tone bit to 0, and set `active_code` to the code. This is a restart even when already busy (retrigger).
- Each cycle in TONE_A or TONE_B with no trigger:
  - `half_cnt`: if 0, toggle the tone bit and reload HALF−1; otherwise decrement.
  - `dur_cnt`: if 0, the segment ends; otherwise decrement.
- Segment end:
  - From TONE_A with `active_code`=go: go to TONE_B. Reload both counters (pong half-period), set tone bit to 0.
  - Otherwise: go to IDLE, tone bit 0, `active_code`=00.
- `speaker` = tone bit AND NOT `mute`. This is combinational after the tone register, so `mute` takes effect with zero latency.
- Counter widths: `$clog2` of the maximum of the parameters; all arithmetic is unsigned, with no wrap below 0 (reload happens at 0).

## Timing
- Reset values: state IDLE, `speaker`=0, `busy`=0, `active_code`=00, counters 0.
- `clr` has priority over `trigger` on the same edge.
- Trigger sampled at edge t:
  - `busy`=1 and `active_code` valid from t+1.
  - First `speaker` rise at edge t+HALF, then a toggle every HALF edges.
- Duration:
  - `busy` stays high for exactly DUR cycles for ping/pong, and 2·DUR for go.
  - `speaker` is 0 from the ending edge onward.
  - Go's TONE_B starts at edge t+DUR, with its first rise at t+DUR+PONG_HALF.
- Trigger on the same edge as a segment end: the trigger wins and restarts.
- `trigger` with stop while idle: no effect.
- Reset mid-tone: IDLE after the reset edge; no residual toggle.

## Structure
- Shared package `sound_pkg` holds:
  - code constants STOP/PONG/PING/GO, also used by the animation block;
  - the state enum IDLE/TONE_A/TONE_B.
- Sub-module `tone_divider`: half-period counter with load, enable and toggle output. It is instantiated once and reloaded with the selected HALF.
- The FSM and duration counter live in the top level.

## Test plan
Parameters for all scenarios: PING_HALF=4, PONG_HALF=6, DUR=40.

1. Reset, then idle for 50 cycles. Required: `speaker`=0, `busy`=0, `active_code`=00 throughout.
2. Trigger ping at t. Required: `busy` 1 for 40 cycles; `speaker` rises at t+4 and toggles every 4 cycles (5 full periods); returns to 0/idle at t+40.
3. Trigger go at t. Required: ping pitch (period 8) until t+40, then pong pitch (period 12); `busy` drops at t+80; `active_code`=11 throughout.
4. Trigger pong, then trigger ping at t+10. Required: restart with ping pitch, first rise at t+14, `busy` drops at t+50. A stop trigger at t+20 instead gives IDLE at t+21.
5. Assert `mute` during ping. Required: `speaker`=0 while muted, with tone phase and `busy` timing unchanged; the wave resumes in phase when unmuted.
6. Assert `clr` together with `trigger` at t=15 of a pong. Required: IDLE and all outputs 0 at t+1; the trigger is ignored.
